// File: rtl/sprite_pkg.sv
// Shared constants and enums for the sprite scheduler: screen/sprite geometry,
// register-write field codes and the frame-update FSM states.
package sprite_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SPRITE_W = 32;
  localparam int SPRITE_H = 32;
  localparam int LIM_X    = SCREEN_W - SPRITE_W;
  localparam int LIM_Y    = SCREEN_H - SPRITE_H;

  typedef enum logic [1:0] {
    FLD_X   = 2'd0,
    FLD_Y   = 2'd1,
    FLD_VEL = 2'd2,
    FLD_EN  = 2'd3
  } wr_field_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_UPDATE  = 2'd1,
    ST_PUBLISH = 2'd2
  } sched_state_t;

endpackage

// File: rtl/sprite_motion_step.sv
// One-axis position step: wraps around the screen by default, or reflects off the
// edges with velocity negation when SPRITE_BOUNCE_EN is defined.
module sprite_motion_step #(
  parameter int VEL_W = 4
) (
  input  logic        [9:0]       pos,
  input  logic signed [VEL_W-1:0] vel,
  input  logic        [9:0]       screen,
  input  logic        [9:0]       lim,
  output logic        [9:0]       pos_nxt,
  output logic signed [VEL_W-1:0] vel_nxt
);

  logic signed [11:0] s;
  logic signed [11:0] r;
  logic signed [11:0] screen_s;
  logic signed [11:0] lim_s;

  assign screen_s = $signed({2'b00, screen});
  assign lim_s    = $signed({2'b00, lim});
  assign s        = $signed({2'b00, pos}) + $signed({{(12-VEL_W){vel[VEL_W-1]}}, vel});

`ifdef SPRITE_BOUNCE_EN
  // Negation that pins the most-negative code to the most-positive one.
  function automatic logic signed [VEL_W-1:0] neg_sat(input logic signed [VEL_W-1:0] v);
    if (v[VEL_W-1] && (v[VEL_W-2:0] == '0))
      return {1'b0, {(VEL_W-1){1'b1}}};
    else
      return -v;
  endfunction

  logic unused_screen;
  assign unused_screen = ^screen;

  always_comb begin
    r       = s;
    vel_nxt = vel;
    if (s < 0) begin
      r       = -s;
      vel_nxt = neg_sat(vel);
    end else if (s > lim_s) begin
      r       = (lim_s <<< 1) - s;
      vel_nxt = neg_sat(vel);
    end
  end
`else
  logic unused_lim;
  assign unused_lim = ^lim;

  always_comb begin
    r       = s;
    vel_nxt = vel;
    if (s < 0)
      r = s + screen_s;
    else if (s >= screen_s)
      r = s - screen_s;
  end
`endif

  assign pos_nxt = r[9:0];

endmodule

// File: rtl/sprite_scheduler.sv
// Frame controller for the sprite renderers: per-slot motion registers, vsync-driven
// update/publish FSM and registered priority pixel arbiter. Optional: SPRITE_BOUNCE_EN.
module sprite_scheduler
  import sprite_pkg::*;
#(
  parameter int N_SPRITES = 4,
  parameter int VEL_W     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    vsync,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [2:0]              wr_slot,
  input  logic [1:0]              wr_field,
  input  logic [9:0]              wr_data,
  output logic [10*N_SPRITES-1:0] sprite_x,
  output logic [10*N_SPRITES-1:0] sprite_y,
  input  logic [N_SPRITES-1:0]    spr_drawing,
  input  logic [N_SPRITES-1:0]    spr_color,
  output logic                    pix_on,
  output logic [2:0]              pix_id,
  output logic                    frame_done
);

  localparam logic [2:0] IDX_LAST = 3'(N_SPRITES - 1);

  logic        [9:0]       pos_x [N_SPRITES];
  logic        [9:0]       pos_y [N_SPRITES];
  logic signed [VEL_W-1:0] vel_x [N_SPRITES];
  logic signed [VEL_W-1:0] vel_y [N_SPRITES];
  logic [N_SPRITES-1:0]    en;

  sched_state_t state, state_nxt;
  logic [2:0]   idx, idx_nxt;
  logic         vsync_q;
  logic         vs_fall;
  logic         wr_fire;

  logic        [9:0]       cur_x, cur_y, nxt_x, nxt_y;
  logic signed [VEL_W-1:0] cur_vx, cur_vy, nxt_vx, nxt_vy;

  logic       win_on_p0;
  logic [2:0] win_id_p0;

  assign vs_fall = vsync_q & ~vsync;
  assign wr_fire = wr_valid & wr_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      vsync_q    <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      vsync_q    <= vsync;
      frame_done <= (state == ST_PUBLISH);
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wr_ready  = 1'b0;
    case (state)
      ST_IDLE: begin
        wr_ready = ~reset;
        if (vs_fall) begin
          state_nxt = ST_UPDATE;
          idx_nxt   = '0;
        end
      end
      ST_UPDATE: begin
        idx_nxt = idx + 3'd1;
        if (idx == IDX_LAST)
          state_nxt = ST_PUBLISH;
      end
      ST_PUBLISH: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Select the slot being stepped this cycle.
  always_comb begin
    cur_x  = '0;
    cur_y  = '0;
    cur_vx = '0;
    cur_vy = '0;
    for (int i = 0; i < N_SPRITES; i++) begin
      if (idx == 3'(i)) begin
        cur_x  = pos_x[i];
        cur_y  = pos_y[i];
        cur_vx = vel_x[i];
        cur_vy = vel_y[i];
      end
    end
  end

  sprite_motion_step #(.VEL_W(VEL_W)) u_step_x (
    .pos     (cur_x),
    .vel     (cur_vx),
    .screen  (10'(SCREEN_W)),
    .lim     (10'(LIM_X)),
    .pos_nxt (nxt_x),
    .vel_nxt (nxt_vx)
  );

  sprite_motion_step #(.VEL_W(VEL_W)) u_step_y (
    .pos     (cur_y),
    .vel     (cur_vy),
    .screen  (10'(SCREEN_H)),
    .lim     (10'(LIM_Y)),
    .pos_nxt (nxt_y),
    .vel_nxt (nxt_vy)
  );

  // Writes only land in IDLE and steps only in UPDATE, so the two never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
        vel_x[i] <= '0;
        vel_y[i] <= '0;
      end
      en       <= '0;
      sprite_x <= '0;
      sprite_y <= '0;
    end else begin
      for (int i = 0; i < N_SPRITES; i++) begin
        if (wr_fire && wr_slot == 3'(i)) begin
          case (wr_field_t'(wr_field))
            FLD_X:   pos_x[i] <= wr_data;
            FLD_Y:   pos_y[i] <= wr_data;
            FLD_VEL: begin
              vel_x[i] <= $signed(wr_data[VEL_W-1:0]);
              vel_y[i] <= $signed(wr_data[2*VEL_W-1:VEL_W]);
            end
            FLD_EN:  en[i] <= wr_data[0];
            default: ;
          endcase
        end
        if (state == ST_UPDATE && idx == 3'(i) && en[i]) begin
          pos_x[i] <= nxt_x;
          pos_y[i] <= nxt_y;
          vel_x[i] <= nxt_vx;
          vel_y[i] <= nxt_vy;
        end
        if (state == ST_PUBLISH) begin
          sprite_x[10*i +: 10] <= pos_x[i];
          sprite_y[10*i +: 10] <= pos_y[i];
        end
      end
    end
  end

  // p0: lowest lit slot wins; transparent pixels do not occlude.
  always_comb begin
    win_on_p0 = 1'b0;
    win_id_p0 = '0;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (en[i] && spr_drawing[i] && spr_color[i]) begin
        win_on_p0 = 1'b1;
        win_id_p0 = 3'(i);
      end
    end
  end

  // p1: registered arbiter output.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_on <= 1'b0;
      pix_id <= '0;
    end else begin
      pix_on <= win_on_p0;
      pix_id <= win_id_p0;
    end
  end

endmodule
